// File: rtl/uart_tx_pkg.sv
// Shared types for the parametrised UART transmitter: FSM state encoding,
// per-frame configuration captured with each word, and a frame length helper.
package uart_tx_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'b000,
        START  = 3'b001,
        DATA   = 3'b011,
        PARITY = 3'b010,
        STOP   = 3'b110
    } state_e;

    typedef struct packed {
        logic par_en;
        logic par_typ;
        logic stop2;
    } frame_cfg_t;

    // Bit times in one frame: start + data + optional parity + one or two stops.
    function automatic int unsigned frame_bits(input int unsigned width,
                                               input logic        par_en,
                                               input logic        stop2);
        return width + 32'd2 + 32'(par_en) + 32'(stop2);
    endfunction

endpackage

// File: rtl/uart_tx_param_if.sv
// Source-side bus of the UART transmitter: parallel word, per-frame config,
// baud divider and the valid/ready handshake.
interface uart_tx_param_if #(
    parameter int DATA_WIDTH = 8,
    parameter int DIV_W      = 16
);
    logic [DATA_WIDTH-1:0] P_DATA;
    logic                  DATA_VALID;
    logic                  DATA_READY;
    logic                  PAR_EN;
    logic                  PAR_TYP;
    logic                  STOP2;
    logic [DIV_W-1:0]      BAUD_DIV;

    modport master (
        output P_DATA, DATA_VALID, PAR_EN, PAR_TYP, STOP2, BAUD_DIV,
        input  DATA_READY
    );

    modport slave (
        input  P_DATA, DATA_VALID, PAR_EN, PAR_TYP, STOP2, BAUD_DIV,
        output DATA_READY
    );
endinterface

// File: rtl/uart_baud_gen.sv
// Bit-time generator: latches the divider on load and emits a one-cycle
// bit_tick_o every div cycles while enabled. A divider of 0 behaves as 1.
module uart_baud_gen #(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             load_i,
    input  logic             en_i,
    input  logic [DIV_W-1:0] div_i,
    output logic             bit_tick_o
);

    logic [DIV_W-1:0] div_q, div_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic             terminal;

    assign terminal   = (cnt_q == div_q - DIV_W'(1));
    assign bit_tick_o = en_i && terminal;

    always_comb begin
        div_d = div_q;
        cnt_d = cnt_q;
        if (load_i) begin
            div_d = (div_i == '0) ? DIV_W'(1) : div_i;
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = terminal ? '0 : cnt_q + DIV_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            div_q <= '0;
            cnt_q <= '0;
        end else begin
            div_q <= div_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx_param.sv
// UART transmitter with a one-entry holding buffer for gap-free frames,
// runtime baud divider, optional parity and one or two stop bits.
module uart_tx_param
    import uart_tx_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DIV_W      = 16
) (
    input  logic            clk,
    input  logic            reset,
    uart_tx_param_if.slave  src,
    output logic            TX_OUT,
    output logic            Busy
);

    localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    state_e                state_q, state_d;
    logic                  buf_full_q, buf_full_d;
    logic [DATA_WIDTH-1:0] buf_data_q, buf_data_d;
    frame_cfg_t            buf_cfg_q, buf_cfg_d;
    logic                  ready_q, ready_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    frame_cfg_t            cfg_q, cfg_d;
    logic                  par_bit_q, par_bit_d;
    logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
    logic                  stop_cnt_q, stop_cnt_d;
    logic                  tx_q, tx_d;
    logic                  busy_q, busy_d;

    logic bit_tick;
    logic accept;
    logic stop_done;
    logic load;

    assign accept    = src.DATA_VALID && ready_q;
    assign stop_done = !cfg_q.stop2 || stop_cnt_q;
    // A frame load happens from IDLE, or straight out of the last stop bit so
    // the next start bit follows without an idle cycle.
    assign load      = buf_full_q &&
                       ((state_q == IDLE) ||
                        (state_q == STOP && bit_tick && stop_done));

    uart_baud_gen #(
        .DIV_W (DIV_W)
    ) u_baud (
        .clk        (clk),
        .srst       (reset),
        .load_i     (load),
        .en_i       (state_q != IDLE),
        .div_i      (src.BAUD_DIV),
        .bit_tick_o (bit_tick)
    );

    always_comb begin
        state_d    = state_q;
        buf_full_d = buf_full_q;
        buf_data_d = buf_data_q;
        buf_cfg_d  = buf_cfg_q;
        shift_d    = shift_q;
        cfg_d      = cfg_q;
        par_bit_d  = par_bit_q;
        bit_cnt_d  = bit_cnt_q;
        stop_cnt_d = stop_cnt_q;

        if (load) begin
            buf_full_d = 1'b0;
        end
        if (accept) begin
            buf_full_d = 1'b1;
            buf_data_d = src.P_DATA;
            buf_cfg_d  = '{par_en: src.PAR_EN, par_typ: src.PAR_TYP, stop2: src.STOP2};
        end
        // Ready is registered from the next buffer state, so it never depends
        // combinationally on DATA_VALID and stays low for a cycle after reset.
        ready_d = !buf_full_d;

        case (state_q)
            IDLE: begin
                if (buf_full_q) begin
                    state_d = START;
                end
            end
            START: begin
                if (bit_tick) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (bit_tick) begin
                    shift_d = shift_q >> 1;
                    if (bit_cnt_q == CNT_W'(DATA_WIDTH - 1)) begin
                        bit_cnt_d = '0;
                        state_d   = cfg_q.par_en ? PARITY : STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    end
                end
            end
            PARITY: begin
                if (bit_tick) begin
                    state_d = STOP;
                end
            end
            STOP: begin
                if (bit_tick) begin
                    if (stop_done) begin
                        stop_cnt_d = 1'b0;
                        state_d    = buf_full_q ? START : IDLE;
                    end else begin
                        stop_cnt_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (load) begin
            shift_d    = buf_data_q;
            cfg_d      = buf_cfg_q;
            par_bit_d  = buf_cfg_q.par_typ ? ^buf_data_q : ~^buf_data_q;
            bit_cnt_d  = '0;
            stop_cnt_d = 1'b0;
        end
    end

    // Line outputs are registered one cycle behind the state they encode.
    always_comb begin
        tx_d   = 1'b1;
        busy_d = (state_q != IDLE);
        case (state_q)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_q[0];
            PARITY:  tx_d = par_bit_q;
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            buf_full_q <= 1'b0;
            buf_data_q <= '0;
            buf_cfg_q  <= '0;
            ready_q    <= 1'b0;
            shift_q    <= '0;
            cfg_q      <= '0;
            par_bit_q  <= 1'b0;
            bit_cnt_q  <= '0;
            stop_cnt_q <= 1'b0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            buf_full_q <= buf_full_d;
            buf_data_q <= buf_data_d;
            buf_cfg_q  <= buf_cfg_d;
            ready_q    <= ready_d;
            shift_q    <= shift_d;
            cfg_q      <= cfg_d;
            par_bit_q  <= par_bit_d;
            bit_cnt_q  <= bit_cnt_d;
            stop_cnt_q <= stop_cnt_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
        end
    end

    assign src.DATA_READY = ready_q;
    assign TX_OUT         = tx_q;
    assign Busy           = busy_q;

endmodule

// File: tb/tb_uart_tx_param.sv
// Scoreboard bench for uart_tx_param: 8-bit and 5-bit instances, expected
// {Busy,TX_OUT} per cycle queued on accept and checked by a monitor.
module tb_uart_tx_param;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    uart_tx_param_if #(.DATA_WIDTH(8), .DIV_W(16)) bus8 ();
    uart_tx_param_if #(.DATA_WIDTH(5), .DIV_W(16)) bus5 ();

    logic [1:0] busy_w;
    logic [1:0] tx_w;

    uart_tx_param #(.DATA_WIDTH(8), .DIV_W(16)) dut8 (
        .clk    (clk),
        .reset  (reset),
        .src    (bus8),
        .TX_OUT (tx_w[0]),
        .Busy   (busy_w[0])
    );

    uart_tx_param #(.DATA_WIDTH(5), .DIV_W(16)) dut5 (
        .clk    (clk),
        .reset  (reset),
        .src    (bus5),
        .TX_OUT (tx_w[1]),
        .Busy   (busy_w[1])
    );

    int         checks = 0;
    int         passes = 0;
    logic [1:0] expq [2][$];
    bit         started [2];
    int         wait_cnt [2];
    bit         mon_en = 1'b0;
    int         st;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Monitor: once Busy rises with expectations pending, every cycle is popped
    // and compared until the queue drains, so gaps or overruns show up.
    always @(negedge clk) begin
        if (mon_en) begin
            for (int c = 0; c < 2; c++) begin
                if (started[c] || (busy_w[c] && expq[c].size() > 0)) begin
                    logic [1:0] e;
                    started[c]  = 1'b1;
                    wait_cnt[c] = 0;
                    e = expq[c].pop_front();
                    check($sformatf("frame ch%0d {busy,tx}", c), 32'({busy_w[c], tx_w[c]}), 32'(e));
                    if (expq[c].size() == 0) started[c] = 1'b0;
                end else if (expq[c].size() == 0) begin
                    check($sformatf("idle ch%0d {busy,tx}", c), 32'({busy_w[c], tx_w[c]}), 32'd1);
                end else begin
                    wait_cnt[c]++;
                    if (wait_cnt[c] > 200) begin
                        check($sformatf("start timeout ch%0d busy", c), 32'(busy_w[c]), 32'd1);
                        expq[c].delete();
                        wait_cnt[c] = 0;
                    end
                end
            end
        end
    end

    task automatic send(input int ch, input logic [8:0] d, input logic pe, input logic pt,
                        input logic s2, input int div, input string exp, output int stalls);
        logic rdy;
        int   reps;
        stalls = 0;
        @(negedge clk);
        if (ch == 0) begin
            bus8.P_DATA = d[7:0]; bus8.PAR_EN = pe; bus8.PAR_TYP = pt;
            bus8.STOP2 = s2; bus8.BAUD_DIV = div[15:0]; bus8.DATA_VALID = 1'b1;
        end else begin
            bus5.P_DATA = d[4:0]; bus5.PAR_EN = pe; bus5.PAR_TYP = pt;
            bus5.STOP2 = s2; bus5.BAUD_DIV = div[15:0]; bus5.DATA_VALID = 1'b1;
        end
        rdy = (ch == 0) ? bus8.DATA_READY : bus5.DATA_READY;
        while (rdy !== 1'b1) begin
            stalls++;
            if (stalls > 500) begin
                check("accept timeout ready", 32'(rdy), 32'd1);
                return;
            end
            @(negedge clk);
            rdy = (ch == 0) ? bus8.DATA_READY : bus5.DATA_READY;
        end
        @(posedge clk);
        reps = (div == 0) ? 1 : div;
        for (int i = 0; i < exp.len(); i++)
            repeat (reps) expq[ch].push_back({1'b1, exp.getc(i) == 8'h31});
    endtask

    task automatic push_idle(input int ch);
        expq[ch].push_back(2'b01);
    endtask

    task automatic finish_test(input int ch);
        int n;
        @(negedge clk);
        bus8.DATA_VALID = 1'b0;
        bus5.DATA_VALID = 1'b0;
        n = 0;
        while (expq[ch].size() != 0 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (expq[ch].size() != 0) check("drain timeout queue size", 32'(expq[ch].size()), 32'd0);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        bus8.DATA_VALID = 1'b0; bus8.P_DATA = '0; bus8.PAR_EN = 1'b0;
        bus8.PAR_TYP = 1'b0; bus8.STOP2 = 1'b0; bus8.BAUD_DIV = 16'd1;
        bus5.DATA_VALID = 1'b0; bus5.P_DATA = '0; bus5.PAR_EN = 1'b0;
        bus5.PAR_TYP = 1'b0; bus5.STOP2 = 1'b0; bus5.BAUD_DIV = 16'd1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset TX_OUT", 32'(tx_w[0]), 32'd1);
        check("reset Busy", 32'(busy_w[0]), 32'd0);
        check("reset DATA_READY", 32'(bus8.DATA_READY), 32'd0);
        check("reset DATA_READY w5", 32'(bus5.DATA_READY), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check("DATA_READY after reset", 32'(bus8.DATA_READY), 32'd1);
        check("DATA_READY after reset w5", 32'(bus5.DATA_READY), 32'd1);
        mon_en = 1'b1;

        // 0xA5, even/odd parity bit = ^data = 0, one stop, div 1
        send(0, 9'h0A5, 1'b1, 1'b1, 1'b0, 1, "01010010101", st);
        push_idle(0);
        finish_test(0);

        // 0x3C, no parity, two stops, each bit 4 cycles
        send(0, 9'h03C, 1'b0, 1'b0, 1'b1, 4, "00011110011", st);
        push_idle(0);
        finish_test(0);

        // back-to-back 0x01 then 0x80
        send(0, 9'h001, 1'b0, 1'b0, 1'b0, 1, "0100000001", st);
        check("first word stalls", 32'(st), 32'd0);
        send(0, 9'h080, 1'b0, 1'b0, 1'b0, 1, "0000000011", st);
        check("second word stalls", 32'(st), 32'd1);
        push_idle(0);
        finish_test(0);

        // third word waits while shifter busy and buffer full
        send(0, 9'h001, 1'b0, 1'b0, 1'b0, 1, "0100000001", st);
        send(0, 9'h080, 1'b0, 1'b0, 1'b0, 1, "0000000011", st);
        check("buffered word stalls", 32'(st), 32'd1);
        send(0, 9'h055, 1'b0, 1'b0, 1'b0, 1, "0101010101", st);
        check("third word stalls", 32'(st), 32'd9);
        push_idle(0);
        finish_test(0);

        // reset during the 5th data bit of 0xFF with 0x3C buffered
        send(0, 9'h0FF, 1'b0, 1'b0, 1'b0, 1, "011111", st);
        send(0, 9'h03C, 1'b0, 1'b0, 1'b0, 1, "", st);
        push_idle(0);
        @(negedge clk);
        bus8.DATA_VALID = 1'b0;
        repeat (5) @(negedge clk);
        check("TX_OUT at 5th data bit", 32'(tx_w[0]), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        check("abort TX_OUT", 32'(tx_w[0]), 32'd1);
        check("abort Busy", 32'(busy_w[0]), 32'd0);
        check("abort DATA_READY", 32'(bus8.DATA_READY), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("DATA_READY after abort", 32'(bus8.DATA_READY), 32'd1);
        repeat (30) @(negedge clk);

        // 5-bit instance, 10101, parity ~^ = 0, divider 0 acts as 1
        send(1, 9'h015, 1'b1, 1'b0, 1'b0, 0, "01010101", st);
        push_idle(1);
        finish_test(1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
